// File: rtl/k_and_s_pkg.sv
// Shared types and opcode map for the K&S processor datapath and control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BNZERO,
    I_BNNEG,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BNZERO = 8'h0A;
  localparam logic [7:0] OP_BNNEG  = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h83;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_ovf;
    logic signed_ovf;
  } alu_flags_t;

endpackage

// File: rtl/ks_flags_reg.sv
// Flags register: four enable-gated flops holding the status of the last
// flag-setting ALU operation.
module ks_flags_reg
  import k_and_s_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  alu_flags_t flags_in,
  output alu_flags_t flags_out
);

  alu_flags_t flags_q, flags_d;

  // NOTE: assign the default first so every path drives flags_d and no latch is inferred.
  always_comb begin
    flags_d = flags_q;
    if (enable) flags_d = flags_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_out = flags_q;

endmodule

// File: rtl/instruction_decoder.sv
// Instruction register, opcode decode and flags register of the K&S processor.
// Define INSTR_COUNT_EN to add a saturating 16-bit count of instruction loads.
module instruction_decoder
  import k_and_s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ir_enable,
  input  logic                    flags_reg_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_unsigned_overflow,
  input  logic                    alu_signed_overflow,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic [1:0]              c_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    illegal_instr
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]             instr_count
`endif
);

  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [7:0]            opcode;
  logic                  ir_unused;

  always_comb begin
    ir_d = ir_q;
    if (ir_enable) ir_d = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ir_q <= '0;
    else        ir_q <= ir_d;
  end

  assign opcode    = ir_q[15:8];
  // Bit 7 of the operand byte belongs to no field in any format.
  assign ir_unused = ir_q[7];

  always_comb begin
    decoded_instruction = I_NOP;
    a_addr              = '0;
    b_addr              = '0;
    c_addr              = '0;
    mem_addr            = '0;
    illegal_instr       = 1'b0;
    unique case (opcode)
      OP_NOP:    decoded_instruction = I_NOP;
      OP_BRANCH: begin
        decoded_instruction = I_BRANCH;
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_BZERO: begin
        decoded_instruction = I_BZERO;
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_BNEG: begin
        decoded_instruction = I_BNEG;
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_BNZERO: begin
        decoded_instruction = I_BNZERO;
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_BNNEG: begin
        decoded_instruction = I_BNNEG;
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_LOAD: begin
        decoded_instruction = I_LOAD;
        c_addr              = ir_q[6:5];
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_STORE: begin
        decoded_instruction = I_STORE;
        a_addr              = ir_q[6:5];
        mem_addr            = ADDR_WIDTH'(ir_q[4:0]);
      end
      OP_MOVE: begin
        decoded_instruction = I_MOVE;
        c_addr              = ir_q[3:2];
        a_addr              = ir_q[1:0];
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        unique case (opcode)
          OP_ADD:  decoded_instruction = I_ADD;
          OP_SUB:  decoded_instruction = I_SUB;
          OP_AND:  decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        c_addr = ir_q[5:4];
        a_addr = ir_q[3:2];
        b_addr = ir_q[1:0];
      end
      OP_HALT:   decoded_instruction = I_HALT;
      default:   illegal_instr = 1'b1;
    endcase
  end

  alu_flags_t alu_flags, flags;

  assign alu_flags = '{zero:         alu_zero,
                       neg:          alu_neg,
                       unsigned_ovf: alu_unsigned_overflow,
                       signed_ovf:   alu_signed_overflow};

  ks_flags_reg u_flags_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (flags_reg_enable),
    .flags_in  (alu_flags),
    .flags_out (flags)
  );

  assign zero_op           = flags.zero;
  assign neg_op            = flags.neg;
  assign unsigned_overflow = flags.unsigned_ovf;
  assign signed_overflow   = flags.signed_ovf;

`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count_q, instr_count_d;

  // A halted core keeps being fed its HALT word; those reloads are not new instructions.
  always_comb begin
    instr_count_d = instr_count_q;
    if (ir_enable && (opcode != OP_HALT) && (instr_count_q != 16'hFFFF))
      instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_count_q <= '0;
    else        instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule
